// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
//   Shared definitions for the instruction fetch buffer.
//   - fetch_entry_t    : one queued instruction together with its address
//   - RESET_PC_DEFAULT : first fetch address after reset
package fetch_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   DEPTH-entry queue of fetch_entry_t. The head is read combinationally from
//   storage, so a pushed entry appears at the head one cycle after the push.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset
//     flush_i          empty the queue; push/pop in the same cycle are ignored
//     push_i, push_data_i  write an entry at the tail
//     pop_i            remove the head entry (ignored when empty)
//     count_o          number of valid entries (0..DEPTH)
//     head_o           entry at the head
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];

  logic push_en;
  logic pop_en;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign push_en = push_i && !flush_i;
  assign pop_en  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) tail_d = tail_q + PTR_ONE;
      if (pop_en)  head_d = head_q + PTR_ONE;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count_q qualifies every entry.
  // When full, a push-with-pop writes the slot being vacated, which is safe
  // because the head is read before the edge.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[tail_q] <= push_data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction fetch front end: issues sequential word fetches to imem,
//   queues returned words with their PC, and flushes on redirect, discarding
//   responses that were already in flight.
//   Ports:
//     clk_i, reset_i                 clock, synchronous active-high reset
//     redirect_i, redirect_pc_i      flush and restart fetching at a new PC
//     req_valid_o, req_addr_o,
//     req_ready_i                    imem request handshake
//     resp_valid_i, resp_data_i      in-order imem responses
//     instr_valid_o, instr_o, pc_o,
//     instr_ready_i                  queue head towards IF/ID
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;

  logic         accept;
  logic         drop_hit;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // Low address bits of the redirect target carry no meaning for word fetch.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc_i[1:0];
  assign redirect_target      = {redirect_pc_i[31:2], 2'b00};

  // Credit: every outstanding request owns a queue slot, so a response can
  // never find the queue full.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign req_valid_o = (credit_used < DEPTH_C) && !redirect_i && !reset_i;
  assign req_addr_o  = fetch_pc_q;
  assign accept      = req_valid_o && req_ready_i;

  assign drop_hit = resp_valid_i && (drop_q != '0);
  assign push     = resp_valid_i && !drop_hit && !redirect_i;

  assign instr_valid_o = (fifo_count != '0) && !reset_i;
  assign pop           = instr_valid_o && instr_ready_i;

  assign push_entry.pc    = resp_pc_q;
  assign push_entry.instr = resp_data_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q;

    case ({accept, resp_valid_i})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase

    if (redirect_i) begin
      // Everything still outstanding after this cycle belongs to the old
      // path; a response arriving right now is discarded directly.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_d     = inflight_q - (resp_valid_i ? CNT_ONE : '0);
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     resp_pc_d  = resp_pc_q + 32'd4;
      if (drop_hit) drop_d     = drop_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_o      (head_entry)
  );

  assign instr_o = head_entry.instr;
  assign pc_o    = head_entry.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0001_0000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        resp_valid_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b0;

  fetch_buffer dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_valid_o   (req_valid_o),
    .req_addr_o    (req_addr_o),
    .req_ready_i   (req_ready_i),
    .resp_valid_i  (resp_valid_i),
    .resp_data_i   (resp_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // imem model: outstanding requests tagged with the fetch epoch they belong to
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t         imem_q[$];
  fetch_entry_t mq[$];          // expected queue contents, head first
  logic [31:0]  exp_fetch;
  int           epoch;
  int           cyc;
  int           total;
  int           bad;
  int           lat_min, lat_max, ready_pct, cons_pct;

  int          acc_cyc[$];
  logic [31:0] acc_addr[$];
  int          out_cyc[$];
  logic [31:0] out_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic clear_logs();
    acc_cyc.delete(); acc_addr.delete(); out_cyc.delete(); out_pc.delete();
  endtask

  // One clock cycle: drive random handshakes and the imem response, compare
  // the DUT outputs with the model, then advance the model across the edge.
  task automatic cycle();
    bit   exp_rv, exp_iv, acc, popd;
    req_t h, r;
    fetch_entry_t e;
    req_ready_i   = ($urandom_range(0, 99) < ready_pct);
    instr_ready_i = ($urandom_range(0, 99) < cons_pct);
    if (!reset_i && imem_q.size() > 0 && imem_q[0].due <= cyc) begin
      resp_valid_i = 1'b1;
      resp_data_i  = mem_word(imem_q[0].addr);
    end else begin
      resp_valid_i = 1'b0;
      resp_data_i  = $urandom;
    end
    #1;
    exp_rv = !reset_i && !redirect_i && (mq.size() + imem_q.size() < DEPTH);
    exp_iv = !reset_i && (mq.size() > 0);
    total++;
    if (req_valid_o !== exp_rv) begin
      bad++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, req_valid_o, exp_rv);
    end
    if (exp_rv) begin
      total++;
      if (req_addr_o !== exp_fetch) begin
        bad++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, req_addr_o, exp_fetch);
      end
    end
    total++;
    if (instr_valid_o !== exp_iv) begin
      bad++;
      $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid_o, exp_iv);
    end
    if (exp_iv) begin
      total++;
      if (pc_o !== mq[0].pc || instr_o !== mq[0].instr) begin
        bad++;
        $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                 cyc, pc_o, instr_o, mq[0].pc, mq[0].instr);
      end
    end
    acc  = exp_rv && req_ready_i;
    popd = exp_iv && instr_ready_i && !redirect_i;
    if (reset_i) begin
      imem_q.delete();
      mq.delete();
      exp_fetch = RPC;
      epoch++;
    end else begin
      if (resp_valid_i) begin
        h = imem_q.pop_front();
        if (h.epoch == epoch && !redirect_i) begin
          e.pc    = h.addr;
          e.instr = mem_word(h.addr);
          mq.push_back(e);
        end
      end
      if (popd) begin
        out_cyc.push_back(cyc);
        out_pc.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (acc) begin
        r.addr  = exp_fetch;
        r.epoch = epoch;
        r.due   = cyc + $urandom_range(lat_min, lat_max);
        imem_q.push_back(r);
        acc_cyc.push_back(cyc);
        acc_addr.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_i) begin
        epoch++;
        mq.delete();
        exp_fetch = redirect_pc_i & ~32'h3;
      end
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset_i    = 1'b1;
    redirect_i = 1'b0;
    repeat (n) cycle();
    reset_i = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    cycle();
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    ready_pct = 100; cons_pct = 100; lat_min = 1; lat_max = 1;
    do_reset(3);
    total++;
    if (dut.fifo_count !== 0 || dut.inflight_q !== 0 || dut.drop_q !== 0) begin
      bad++;
      $display("FAIL reset_counters got count=%0d inflight=%0d drop=%0d exp 0/0/0",
               dut.fifo_count, dut.inflight_q, dut.drop_q);
    end
    total++;
    if (dut.fetch_pc_q !== RPC) begin
      bad++;
      $display("FAIL reset_pc got=%h exp=%h", dut.fetch_pc_q, RPC);
    end
    $display("test_reset: done at cyc=%0d", cyc);
  endtask

  task automatic test_basic();
    int rel;
    ready_pct = 100; cons_pct = 100; lat_min = 1; lat_max = 1;
    clear_logs();
    rel = cyc;
    repeat (8) cycle();
    total++;
    if (acc_addr.size() < 3) begin
      bad++;
      $display("FAIL basic_accepts got=%0d exp>=3", acc_addr.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (acc_addr[k] !== RPC + 32'(4 * k) || acc_cyc[k] !== rel + k) begin
          bad++;
          $display("FAIL basic_req%0d got addr=%h cyc=%0d exp addr=%h cyc=%0d",
                   k, acc_addr[k], acc_cyc[k], RPC + 32'(4 * k), rel + k);
        end
      end
    end
    total++;
    if (out_cyc.size() == 0) begin
      bad++;
      $display("FAIL basic_out got=none exp=output");
    end else if (out_cyc[0] !== rel + 2 || out_pc[0] !== RPC) begin
      bad++;
      $display("FAIL basic_first_out got cyc=%0d pc=%h exp cyc=%0d pc=%h",
               out_cyc[0], out_pc[0], rel + 2, RPC);
    end
    $display("test_basic: accepts=%0d outputs=%0d", acc_addr.size(), out_pc.size());
  endtask

  task automatic test_stall();
    int n0, p;
    do_reset(2);
    ready_pct = 100; cons_pct = 0; lat_min = 1; lat_max = 1;
    clear_logs();
    repeat (10) cycle();
    total++;
    if (acc_addr.size() !== DEPTH) begin
      bad++;
      $display("FAIL stall_accepts got=%0d exp=%0d", acc_addr.size(), DEPTH);
    end
    total++;
    if (dut.fifo_count !== DEPTH || req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_full got count=%0d req_valid=%b exp count=%0d req_valid=0",
               dut.fifo_count, req_valid_o, DEPTH);
    end
    for (int k = 0; k < 2; k++) begin
      n0 = acc_addr.size();
      p  = cyc;
      cons_pct = 100;
      cycle();
      cons_pct = 0;
      repeat (5) cycle();
      total++;
      if (acc_addr.size() !== n0 + 1 || acc_cyc[acc_cyc.size() - 1] !== p + 1) begin
        bad++;
        $display("FAIL stall_pop%0d got accepts=%0d last_cyc=%0d exp accepts=%0d cyc=%0d",
                 k, acc_addr.size() - n0, acc_cyc[acc_cyc.size() - 1], 1, p + 1);
      end
    end
    $display("test_stall: accepts=%0d", acc_addr.size());
  endtask

  task automatic test_redirect();
    int stale;
    do_reset(2);
    ready_pct = 100; cons_pct = 100; lat_min = 5; lat_max = 5;
    repeat (3) cycle();
    clear_logs();
    do_redirect(32'h0002_0003);
    total++;
    if (dut.drop_q !== 3) begin
      bad++;
      $display("FAIL redirect_drop got=%0d exp=3", dut.drop_q);
    end
    repeat (25) cycle();
    stale = 0;
    foreach (out_pc[k]) if (out_pc[k] < 32'h0002_0000) stale++;
    total++;
    if (out_pc.size() == 0 || out_pc[0] !== 32'h0002_0000 || stale != 0) begin
      bad++;
      $display("FAIL redirect_first got n=%0d pc=%h stale=%0d exp pc=00020000 stale=0",
               out_pc.size(), (out_pc.size() > 0) ? out_pc[0] : 32'hx, stale);
    end
    $display("test_redirect: outputs=%0d", out_pc.size());
  endtask

  task automatic test_redirect_resp();
    bit found;
    int exp_drop;
    do_reset(2);
    ready_pct = 100; cons_pct = 100; lat_min = 2; lat_max = 2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_q.size() > 0 && imem_q[0].due <= cyc && mq.size() > 0) found = 1;
      else cycle();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL redirect_resp_setup got=none exp=resp+pop cycle");
    end else begin
      exp_drop = imem_q.size() - 1;
      clear_logs();
      do_redirect(32'h0003_0000);
      total++;
      if (dut.drop_q !== exp_drop || dut.fifo_count !== 0) begin
        bad++;
        $display("FAIL redirect_resp got drop=%0d count=%0d exp drop=%0d count=0",
                 dut.drop_q, dut.fifo_count, exp_drop);
      end
      repeat (15) cycle();
      total++;
      if (out_pc.size() == 0 || out_pc[0] !== 32'h0003_0000) begin
        bad++;
        $display("FAIL redirect_resp_first got n=%0d exp pc=00030000", out_pc.size());
      end
    end
    $display("test_redirect_resp: done at cyc=%0d", cyc);
  endtask

  task automatic test_back_to_back();
    int exp_drop;
    ready_pct = 100; cons_pct = 100; lat_min = 3; lat_max = 3;
    repeat (4) cycle();
    do_redirect(32'h0004_0000);
    exp_drop = imem_q.size() - ((imem_q.size() > 0 && imem_q[0].due <= cyc) ? 1 : 0);
    clear_logs();
    do_redirect(32'h0005_0000);
    total++;
    if (dut.drop_q !== exp_drop) begin
      bad++;
      $display("FAIL b2b_drop got=%0d exp=%0d", dut.drop_q, exp_drop);
    end
    repeat (20) cycle();
    total++;
    if (out_pc.size() == 0 || out_pc[0] !== 32'h0005_0000) begin
      bad++;
      $display("FAIL b2b_first got n=%0d exp pc=00050000", out_pc.size());
    end
    $display("test_back_to_back: outputs=%0d", out_pc.size());
  endtask

  task automatic test_wrap();
    ready_pct = 100; cons_pct = 100; lat_min = 1; lat_max = 1;
    do_redirect(32'hFFFF_FFFC);
    clear_logs();
    repeat (8) cycle();
    total++;
    if (acc_addr.size() < 2 || acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_addr got n=%0d exp FFFFFFFC then 00000000", acc_addr.size());
    end
    total++;
    if (out_pc.size() < 2 || out_pc[1] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_out got n=%0d exp second pc=00000000", out_pc.size());
    end
    $display("test_wrap: accepts=%0d", acc_addr.size());
  endtask

  task automatic test_random();
    do_reset(2);
    ready_pct = 70; cons_pct = 60; lat_min = 1; lat_max = 5;
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset(1);
      else if ($urandom_range(0, 49) == 0) do_redirect($urandom);
      else cycle();
    end
    total++;
    if (out_pc.size() < 200) begin
      bad++;
      $display("FAIL random_throughput got=%0d exp>=200", out_pc.size());
    end
    $display("test_random: accepts=%0d outputs=%0d", acc_addr.size(), out_pc.size());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; epoch = 0; exp_fetch = RPC;
    ready_pct = 100; cons_pct = 100; lat_min = 1; lat_max = 1;
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_resp();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
